// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg -- shared definitions for the handshaked sequential ALU.
//   Opcode encodings, FSM state enum, iterative-datapath mode enum and
//   flag bit indices.
//   Optional feature macro: ALU_SEQ_MUL_EN (adds the MUL state; without it
//   opcode 10 decodes as illegal).
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_ASR  = 4'd8;
  localparam logic [3:0] OP_PASS = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  // Bit positions when the four flags are viewed as one vector {c,z,n,v}.
  localparam int FLAG_V = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SHIFT,
    ST_DONE
`ifdef ALU_SEQ_MUL_EN
    , ST_MUL
`endif
  } state_e;

  typedef enum logic [1:0] {
    IT_SHL,
    IT_SHR,
    IT_ASR,
    IT_MUL
  } iter_mode_e;

  function automatic logic op_is_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if -- operand/result bus of alu_seq.
//   Input port : in_valid/in_ready with a, b, op.
//   Output port: out_valid/out_ready with result, flag_c/z/n/v, err.
//   Handshake: a transfer happens on a rising edge where valid && ready;
//   the producer holds valid and payload stable until that edge, and
//   ready may depend combinationally on state but never on valid.
//   master = operand source / result sink, slave = the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;
  logic             err;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v, err
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v, err
  );
endinterface

// File: rtl/alu_seq_iter.sv
// alu_seq_iter -- iterative datapath for shifts (one bit per step) and,
//   with ALU_SEQ_MUL_EN, shift-add multiply (WIDTH steps).
//   clk, reset : clock, synchronous active-high reset
//   load       : capture a, b, mode and the iteration count
//   step       : perform one iteration while the count is non-zero
//   mode       : IT_SHL / IT_SHR / IT_ASR / IT_MUL
//   a, b       : operand, shift amount (low SHW bits) or multiplier
//   done       : count has reached zero
//   result     : shifted value or low WIDTH bits of the product
//   carry      : last bit shifted out (0 for amount 0 and for MUL)
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  iter_mode_e       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;  // must hold WIDTH for the multiply

  logic [CW-1:0]    count;
  iter_mode_e       mode_q;
  logic [WIDTH-1:0] data;
  logic             carry_q;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
`else
  // Only the shift amount bits of b are needed without the multiplier.
  logic unused_b_hi;
  assign unused_b_hi = ^b[WIDTH-1:SHW];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      mode_q  <= IT_SHL;
      data    <= '0;
      carry_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mplier  <= '0;
      acc     <= '0;
`endif
    end else if (load) begin
      mode_q  <= mode;
      data    <= a;
      carry_q <= 1'b0;
      count   <= {1'b0, b[SHW-1:0]};
`ifdef ALU_SEQ_MUL_EN
      mplier  <= b;
      acc     <= '0;
      if (mode == IT_MUL) count <= CW'(WIDTH);
`endif
    end else if (step && (count != '0)) begin
      count <= count - CW'(1);
      case (mode_q)
        IT_SHL: begin
          carry_q <= data[WIDTH-1];
          data    <= data << 1;
        end
        IT_SHR: begin
          carry_q <= data[0];
          data    <= data >> 1;
        end
        IT_ASR: begin
          carry_q <= data[0];
          data    <= {data[WIDTH-1], data[WIDTH-1:1]};
        end
`ifdef ALU_SEQ_MUL_EN
        IT_MUL: begin
          // data is the multiplicand, shifted left once per step.
          if (mplier[0]) acc <= acc + data;
          data   <= data << 1;
          mplier <= mplier >> 1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign done  = (count == '0);
  assign carry = carry_q;
`ifdef ALU_SEQ_MUL_EN
  assign result = (mode_q == IT_MUL) ? acc : data;
`else
  assign result = data;
`endif

endmodule

// File: rtl/alu_seq.sv
// alu_seq -- handshaked sequential ALU, one operation in flight.
//   clk       : clock, rising edge
//   reset     : synchronous, active-high
//   bus       : alu_seq_if.slave (in_valid/in_ready/a/b/op,
//               out_valid/out_ready/result/flag_c/z/n/v/err)
//   dbg_state : current FSM state
//   Macro ALU_SEQ_MUL_EN enables opcode 10 (MUL) and its state.
//   Arithmetic/logic/PASS/illegal ops finish one cycle after acceptance;
//   shifts take 1+amount cycles; MUL takes 1+WIDTH cycles. Results and
//   flags are loaded only on entry to DONE and held there until consumed.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic   clk,
  input  logic   reset,
  alu_seq_if.slave bus,
  output state_e dbg_state
);
  state_e state, next;

  logic             accept;
  logic             in_ready_int;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;

  logic             iter_load, iter_step, iter_done, iter_carry;
  logic [WIDTH-1:0] iter_res;
  iter_mode_e       iter_mode;

  logic [WIDTH-1:0] exec_res;
  logic             exec_c, exec_v, exec_err;
  logic [WIDTH:0]   sum_ext;

  logic             to_done;
  logic [WIDTH-1:0] fin_res;

  logic [WIDTH-1:0] result_q;
  logic             c_q, z_q, n_q, v_q, err_q;

  assign in_ready_int = (state == ST_IDLE) && !reset;
  assign accept       = bus.in_valid && in_ready_int;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next;
  end

  always_comb begin
    next      = state;
    iter_load = 1'b0;
    iter_step = 1'b0;
    iter_mode = IT_MUL;
    case (bus.op)
      OP_SHL:  iter_mode = IT_SHL;
      OP_SHR:  iter_mode = IT_SHR;
      OP_ASR:  iter_mode = IT_ASR;
      default: iter_mode = IT_MUL;
    endcase
    case (state)
      ST_IDLE: begin
        if (accept) begin
          next = ST_EXEC;
          if (op_is_shift(bus.op)) begin
            next      = ST_SHIFT;
            iter_load = 1'b1;
          end
`ifdef ALU_SEQ_MUL_EN
          if (bus.op == OP_MUL) begin
            next      = ST_MUL;
            iter_load = 1'b1;
          end
`endif
        end
      end
      ST_EXEC: next = ST_DONE;
      ST_SHIFT: begin
        iter_step = 1'b1;
        if (iter_done) next = ST_DONE;
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: begin
        iter_step = 1'b1;
        if (iter_done) next = ST_DONE;
      end
`endif
      ST_DONE: if (bus.out_ready) next = ST_IDLE;
      default: next = ST_IDLE;
    endcase
  end

  // ---------------- operand capture ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else if (accept) begin
      a_q  <= bus.a;
      b_q  <= bus.b;
      op_q <= bus.op;
    end
  end

  // ---------------- iterative datapath ----------------
  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (iter_load),
    .step   (iter_step),
    .mode   (iter_mode),
    .a      (bus.a),
    .b      (bus.b),
    .done   (iter_done),
    .result (iter_res),
    .carry  (iter_carry)
  );

  // ---------------- single-cycle datapath ----------------
  // Only consumed in EXEC; shift/MUL opcodes fall into the illegal arm
  // here but never reach EXEC.
  always_comb begin
    exec_res = '0;
    exec_c   = 1'b0;
    exec_v   = 1'b0;
    exec_err = 1'b0;
    sum_ext  = '0;
    case (op_q)
      OP_ADD: begin
        sum_ext  = {1'b0, a_q} + {1'b0, b_q};
        exec_res = sum_ext[WIDTH-1:0];
        exec_c   = sum_ext[WIDTH];
        exec_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                   (sum_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        // A + ~B + 1: carry out of 1 means no borrow.
        sum_ext  = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
        exec_res = sum_ext[WIDTH-1:0];
        exec_c   = sum_ext[WIDTH];
        exec_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                   (sum_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  exec_res = a_q & b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_XOR:  exec_res = a_q ^ b_q;
      OP_NOT:  exec_res = ~a_q;
      OP_PASS: exec_res = b_q;
      default: exec_err = 1'b1;
    endcase
  end

  // ---------------- output registers ----------------
  assign to_done = (state != ST_DONE) && (next == ST_DONE);
  assign fin_res = (state == ST_EXEC) ? exec_res : iter_res;

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      err_q    <= 1'b0;
    end else if (to_done) begin
      result_q <= fin_res;
      z_q      <= (fin_res == '0);
      n_q      <= fin_res[WIDTH-1];
      if (state == ST_EXEC) begin
        c_q   <= exec_c;
        v_q   <= exec_v;
        err_q <= exec_err;
      end else begin
        c_q   <= iter_carry;
        v_q   <= 1'b0;
        err_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = (state == ST_DONE);
  assign bus.result    = result_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_v    = v_q;
  assign bus.err       = err_q;
  assign dbg_state     = state;

endmodule
